ref_clk_train_ctrl: RTL and testbench

Sequencer for the DDR4 reference-clock training IOD lane. It drives the IOD dynamic delay-line controls (LOAD/MOVE/DIRECTION) and samples the deserialised clock word (RX_DATA) tap by tap. It finds the tap where the sampled clock pattern flips, then backs off to a fixed offset from that edge. It sits between the DDRPHY training FSM (start/done/error) and the IOD, in the FAB_CLK domain.

---
 rtl/ref_clk_train_pkg.sv | 23 ++
 rtl/ref_clk_train_ctrl_if.sv | 29 ++
 rtl/ref_clk_train_settle_cnt.sv | 27 ++
 rtl/ref_clk_train_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ref_clk_train_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ref_clk_train_pkg.sv
// rtl/ref_clk_train_pkg.sv - shared state encoding and sample patterns for reference-clock training
package ref_clk_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_REF,
    ST_SAMPLE,
    ST_STEP_UP,
    ST_BACK,
    ST_DONE,
    ST_ERR
  } train_state_t;

  localparam logic [7:0] PAT_ALL0 = 8'h00;
  localparam logic [7:0] PAT_ALL1 = 8'hFF;

  function automatic logic is_flat_word(input logic [7:0] w);
    return (w == PAT_ALL0) || (w == PAT_ALL1);
  endfunction

endpackage

// File: rtl/ref_clk_train_ctrl_if.sv
// rtl/ref_clk_train_ctrl_if.sv - training handshake and IOD delay-line bundle
interface ref_clk_train_ctrl_if #(
  parameter int TAP_W = 8
);
  logic             TRAIN_START;
  logic [7:0]       RX_DATA;
  logic             DELAY_LINE_OUT_OF_RANGE;
  logic             DELAY_LINE_LOAD;
  logic             DELAY_LINE_MOVE;
  logic             DELAY_LINE_DIRECTION;
  logic             EYE_MONITOR_CLEAR_FLAGS;
  logic             BUSY;
  logic             TRAIN_DONE;
  logic             TRAIN_ERR;
  logic [TAP_W-1:0] TAP_COUNT;
  logic [TAP_W-1:0] EDGE_TAP;

  modport master (
    output TRAIN_START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP
  );

  modport slave (
    input  TRAIN_START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP
  );
endinterface

// File: rtl/ref_clk_train_settle_cnt.sv
// rtl/ref_clk_train_settle_cnt.sv - loadable down-counter with zero flag for delay-line settling
module ref_clk_train_settle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ref_clk_train_ctrl.sv
// rtl/ref_clk_train_ctrl.sv - reference-clock IOD training sequencer: sweep taps up to the clock edge, then back off
module ref_clk_train_ctrl #(
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 255,
  parameter int SETTLE_CYCLES = 8,
  parameter int CONFIRM       = 3,
  parameter int BACKOFF_TAPS  = 16
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  ref_clk_train_ctrl_if.slave  bus
);
  import ref_clk_train_pkg::*;

  localparam int SET_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int CONF_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

  train_state_t     r_state;
  train_state_t     r_ret;
  logic             r_load;
  logic             r_move;
  logic             r_dir;
  logic             r_clear;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_edge;
  logic [7:0]       r_ref;
  logic [CONF_W-1:0] r_conf;

  logic             w_settle_done;
  logic             w_settle_load;
  logic             w_settle_en;
  logic [TAP_W-1:0] w_target;

  // Counter is held at its reload value outside SETTLE so each round lasts exactly SETTLE_CYCLES.
  assign w_settle_load = (r_state != ST_SETTLE);
  assign w_settle_en   = (r_state == ST_SETTLE);

  assign w_target = (r_edge >= TAP_W'(BACKOFF_TAPS)) ? (r_edge - TAP_W'(BACKOFF_TAPS)) : '0;

  ref_clk_train_settle_cnt #(
    .CNT_W (SET_W)
  ) u_settle (
    .clk        (FAB_CLK),
    .rst_n      (ARST_N),
    .i_load     (w_settle_load),
    .i_load_val (SET_W'(SETTLE_CYCLES - 1)),
    .i_en       (w_settle_en),
    .o_done     (w_settle_done)
  );

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_REF;
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_dir   <= 1'b0;
      r_clear <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tap   <= '0;
      r_edge  <= '0;
      r_ref   <= '0;
      r_conf  <= '0;
    end else begin
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_clear <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.TRAIN_START) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_edge  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_load  <= 1'b1;
          r_tap   <= '0;
          r_conf  <= '0;
          r_ret   <= ST_REF;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_settle_done) begin
            r_state <= r_ret;
          end
        end
        ST_REF: begin
          r_ref <= bus.RX_DATA;
          if (is_flat_word(bus.RX_DATA)) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (bus.RX_DATA == r_ref) begin
            r_conf  <= '0;
            r_state <= ST_STEP_UP;
          end else if (r_conf == CONF_W'(CONFIRM - 1)) begin
            r_conf  <= '0;
            r_edge  <= r_tap;
            r_state <= ST_BACK;
          end else begin
            // Re-sample the same tap after another settle round to reject glitches.
            r_conf  <= r_conf + 1'b1;
            r_ret   <= ST_SAMPLE;
            r_state <= ST_SETTLE;
          end
        end
        ST_STEP_UP: begin
          if ((r_tap == TAP_W'(MAX_TAP)) || bus.DELAY_LINE_OUT_OF_RANGE) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_move  <= 1'b1;
            r_dir   <= 1'b1;
            r_tap   <= r_tap + 1'b1;
            r_ret   <= ST_SAMPLE;
            r_state <= ST_SETTLE;
          end
        end
        ST_BACK: begin
          if (r_tap > w_target) begin
            r_move  <= 1'b1;
            r_dir   <= 1'b0;
            r_tap   <= r_tap - 1'b1;
            r_ret   <= ST_BACK;
            r_state <= ST_SETTLE;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_clear <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.DELAY_LINE_LOAD         = r_load;
  assign bus.DELAY_LINE_MOVE         = r_move;
  assign bus.DELAY_LINE_DIRECTION    = r_dir;
  assign bus.EYE_MONITOR_CLEAR_FLAGS = r_clear;
  assign bus.BUSY                    = r_busy;
  assign bus.TRAIN_DONE              = r_done;
  assign bus.TRAIN_ERR               = r_err;
  assign bus.TAP_COUNT               = r_tap;
  assign bus.EDGE_TAP                = r_edge;

endmodule

// File: tb/tb_ref_clk_train_ctrl.sv
// tb/tb_ref_clk_train_ctrl.sv - randomized self-checking bench with an IOD delay-line model
module tb_ref_clk_train_ctrl;

  localparam int TAP_W   = 8;
  localparam int BUDGET  = 6000;

  logic FAB_CLK = 1'b0;
  logic ARST_N  = 1'b0;

  ref_clk_train_ctrl_if #(.TAP_W(TAP_W)) bus ();

  ref_clk_train_ctrl #(
    .TAP_W         (8),
    .MAX_TAP       (255),
    .SETTLE_CYCLES (8),
    .CONFIRM       (3),
    .BACKOFF_TAPS  (16)
  ) dut (
    .FAB_CLK (FAB_CLK),
    .ARST_N  (ARST_N),
    .bus     (bus.slave)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int n_checks = 0;
  int n_errors = 0;

  // IOD model state, owned by the monitor process
  int   iod_tap = 0;
  int   cyc_at_tap = 0;
  int   n_load = 0, n_up = 0, n_dn = 0, n_clr = 0;
  logic prev_dir = 1'b0;
  byte  pulse_log[$];

  // scenario knobs, owned by the main process
  int sc_edge = 40, sc_glitch = 0, sc_stuck = 0, sc_oor = 1000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] iod_word(input int tap, input int cyc);
    if (sc_stuck != 0) return 8'hFF;
    if ((sc_glitch != 0) && (tap == 20) && (cyc < 22)) return 8'hAA;
    return (tap < sc_edge) ? 8'h55 : 8'hAA;
  endfunction

  initial begin
    bus.TRAIN_START             = 1'b0;
    bus.RX_DATA                 = 8'h55;
    bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
    forever begin
      @(negedge FAB_CLK);
      if (!ARST_N) begin
        iod_tap    = 0;
        cyc_at_tap = 0;
        prev_dir   = 1'b0;
        check("reset_quiet", {26'd0, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE,
              bus.EYE_MONITOR_CLEAR_FLAGS, bus.BUSY, bus.TRAIN_DONE, bus.TRAIN_ERR}, 32'd0);
      end else begin
        check("single_pulse", {31'd0, bus.DELAY_LINE_LOAD & bus.DELAY_LINE_MOVE}, 32'd0);
        if (bus.DELAY_LINE_LOAD) begin
          iod_tap = 0; cyc_at_tap = 0; n_load++; pulse_log.push_back("L");
        end else if (bus.DELAY_LINE_MOVE) begin
          if (bus.DELAY_LINE_DIRECTION) begin
            iod_tap++; n_up++; pulse_log.push_back("U");
          end else begin
            iod_tap--; n_dn++; pulse_log.push_back("D");
          end
          cyc_at_tap = 0;
        end else begin
          cyc_at_tap++;
          check("dir_hold", {31'd0, bus.DELAY_LINE_DIRECTION}, {31'd0, prev_dir});
        end
        prev_dir = bus.DELAY_LINE_DIRECTION;
        if (bus.EYE_MONITOR_CLEAR_FLAGS) n_clr++;
        check("clear_with_done", {31'd0, bus.EYE_MONITOR_CLEAR_FLAGS & ~bus.TRAIN_DONE}, 32'd0);
        check("tap_track", {24'd0, bus.TAP_COUNT}, iod_tap);
        check("status_excl", {31'd0, (bus.BUSY & (bus.TRAIN_DONE | bus.TRAIN_ERR)) |
              (bus.TRAIN_DONE & bus.TRAIN_ERR)}, 32'd0);
      end
      bus.RX_DATA                 = iod_word(iod_tap, cyc_at_tap);
      bus.DELAY_LINE_OUT_OF_RANGE = (iod_tap >= sc_oor);
    end
  end

  task automatic pulse_start();
    @(negedge FAB_CLK);
    bus.TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    bus.TRAIN_START = 1'b0;
  endtask

  task automatic run_scn(input string nm, input int e, input int g, input int s, input int oor);
    int b_up, b_dn, b_ld, b_clr, b_log, t, lim;
    int exp_up, exp_dn, exp_tap, exp_edge, exp_done, exp_clr;
    sc_edge = e; sc_glitch = g; sc_stuck = s; sc_oor = oor;
    @(negedge FAB_CLK);
    b_up = n_up; b_dn = n_dn; b_ld = n_load; b_clr = n_clr; b_log = pulse_log.size();
    pulse_start();
    check({nm, "_busy"}, {31'd0, bus.BUSY}, 32'd1);
    check({nm, "_cleared"}, {23'd0, bus.TRAIN_DONE, bus.TRAIN_ERR, bus.EDGE_TAP}, 32'd0);
    t = 0;
    while (!(bus.TRAIN_DONE || bus.TRAIN_ERR) && t < BUDGET) begin
      @(negedge FAB_CLK);
      t++;
    end
    check({nm, "_in_time"}, {31'd0, t < BUDGET}, 32'd1);
    repeat (3) @(negedge FAB_CLK);
    #1;
    // Expected outcome from the sweep rules: edge is found iff reachable before the limit.
    lim = (oor < 255) ? oor : 255;
    if (s != 0) begin
      exp_done = 0; exp_up = 0; exp_dn = 0; exp_tap = 0; exp_edge = 0; exp_clr = 0;
    end else if (e <= lim) begin
      exp_done = 1; exp_up = e; exp_edge = e;
      exp_tap  = (e > 16) ? e - 16 : 0;
      exp_dn   = e - exp_tap; exp_clr = 1;
    end else begin
      exp_done = 0; exp_up = lim; exp_dn = 0; exp_tap = lim; exp_edge = 0; exp_clr = 0;
    end
    check({nm, "_done"}, {31'd0, bus.TRAIN_DONE}, exp_done);
    check({nm, "_err"}, {31'd0, bus.TRAIN_ERR}, 1 - exp_done);
    check({nm, "_busy_end"}, {31'd0, bus.BUSY}, 32'd0);
    check({nm, "_tap"}, {24'd0, bus.TAP_COUNT}, exp_tap);
    check({nm, "_edge"}, {24'd0, bus.EDGE_TAP}, exp_edge);
    check({nm, "_ups"}, n_up - b_up, exp_up);
    check({nm, "_downs"}, n_dn - b_dn, exp_dn);
    check({nm, "_loads"}, n_load - b_ld, 32'd1);
    check({nm, "_clears"}, n_clr - b_clr, exp_clr);
    check({nm, "_load_first"}, (pulse_log.size() > b_log) ? pulse_log[b_log] : 8'd0, "L");
  endtask

  initial begin
    int t, e;
    ARST_N = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check("rst_tap", {24'd0, bus.TAP_COUNT}, 32'd0);
    check("rst_edge", {24'd0, bus.EDGE_TAP}, 32'd0);
    check("rst_dir", {31'd0, bus.DELAY_LINE_DIRECTION}, 32'd0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    run_scn("edge40", 40, 0, 0, 1000);
    check("edge40_pin_edge", {24'd0, bus.EDGE_TAP}, 32'd40);
    check("edge40_pin_tap", {24'd0, bus.TAP_COUNT}, 32'd24);

    run_scn("edge10", 10, 0, 0, 1000);
    check("edge10_pin_tap", {24'd0, bus.TAP_COUNT}, 32'd0);

    run_scn("glitch", 30, 1, 0, 1000);
    check("glitch_pin_edge", {24'd0, bus.EDGE_TAP}, 32'd30);

    run_scn("stuck", 40, 0, 1, 1000);
    run_scn("noedge", 1000, 0, 0, 1000);
    check("noedge_pin_tap", {24'd0, bus.TAP_COUNT}, 32'd255);

    run_scn("oor", 1000, 0, 0, 100);
    check("oor_pin_tap", {24'd0, bus.TAP_COUNT}, 32'd100);

    for (int i = 0; i < 3; i++) begin
      e = $urandom_range(1, 80);
      run_scn("rand", e, 0, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : 1000);
    end

    // Abort mid-sweep with an asynchronous reset, then retrain cleanly.
    sc_edge = 40; sc_glitch = 0; sc_stuck = 0; sc_oor = 1000;
    t = n_up;
    pulse_start();
    e = 0;
    while ((n_up - t) < 5 && e < BUDGET) begin
      @(negedge FAB_CLK);
      e++;
    end
    check("abort_reached", {31'd0, e < BUDGET}, 32'd1);
    repeat (4) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1;
    check("abort_outs", {26'd0, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE, bus.EYE_MONITOR_CLEAR_FLAGS,
          bus.BUSY, bus.TRAIN_DONE, bus.TRAIN_ERR}, 32'd0);
    check("abort_tap", {24'd0, bus.TAP_COUNT}, 32'd0);
    check("abort_dir", {31'd0, bus.DELAY_LINE_DIRECTION}, 32'd0);
    repeat (4) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    run_scn("rerun", 40, 0, 0, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
